// File: rtl/kros_pkg.sv
// Shared KROS definitions: pushbutton FSM states, channel indices and a
// counter width helper.
package kros_pkg;

    typedef enum logic [1:0] {
        UP     = 2'd0,
        DN_CHK = 2'd1,
        DOWN   = 2'd2,
        UP_CHK = 2'd3
    } pb_state_e;

    localparam int FREQ_UP = 0;
    localparam int FREQ_DN = 1;
    localparam int SEQ_UP  = 2;
    localparam int SEQ_DN  = 3;
    localparam int NUM_PB  = 4;

    // Width able to hold (largest timing parameter - 1).
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pb_conditioner_if.sv
// Pushbutton pins in, conditioned step pulses and held levels out.
interface pb_conditioner_if;
    logic       pb_freq_up;
    logic       pb_freq_dn;
    logic       pb_seq_up;
    logic       pb_seq_dn;
    logic       freq_up_p;
    logic       freq_dn_p;
    logic       seq_up_p;
    logic       seq_dn_p;
    logic [3:0] held;

    modport master (
        output pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn,
        input  freq_up_p, freq_dn_p, seq_up_p, seq_dn_p, held
    );

    modport slave (
        input  pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn,
        output freq_up_p, freq_dn_p, seq_up_p, seq_dn_p, held
    );
endinterface

// File: rtl/pb_channel.sv
// One pushbutton: 2-FF synchroniser, debounce FSM, registered press pulse and
// optional auto-repeat while held.
module pb_channel
    import kros_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic press,
    output logic held
);
    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic          s;
    pb_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          press_q, press_d;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= UP;
            cnt_q   <= '0;
            hold_q  <= '0;
            rep_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            press_q <= press_d;
        end
    end

    // hold restarts from zero at each pulse; rep_q selects delay vs period
    // as the terminal count, so the counter can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        press_d = 1'b0;
        case (state_q)
            UP: begin
                if (!s) begin
                    state_d = DN_CHK;
                    cnt_d   = '0;
                end
            end
            DN_CHK: begin
                if (s) begin
                    state_d = UP;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                    hold_d  = '0;
                    rep_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (s) begin
                    state_d = UP_CHK;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (hold_q == (rep_q ? PER_LAST : DLY_LAST)) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            UP_CHK: begin
                if (!s) begin
                    state_d = DOWN;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = UP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = UP;
        endcase
    end

    assign press = press_q;
    assign held  = (state_q == DOWN) || (state_q == UP_CHK);

endmodule

// File: rtl/pb_conditioner.sv
// KROS pushbutton front end: four conditioned channels with up/down pair
// conflict suppression on the step pulses.
module pb_conditioner
    import kros_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic             CLK_50,
    input  logic             reset,
    pb_conditioner_if.slave  bus
);
    logic [NUM_PB-1:0] pin;
    logic [NUM_PB-1:0] press;
    logic [NUM_PB-1:0] held;

    assign pin[FREQ_UP] = bus.pb_freq_up;
    assign pin[FREQ_DN] = bus.pb_freq_dn;
    assign pin[SEQ_UP]  = bus.pb_seq_up;
    assign pin[SEQ_DN]  = bus.pb_seq_dn;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        pb_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (CLK_50),
            .rst_n (reset),
            .pin   (pin[i]),
            .press (press[i]),
            .held  (held[i])
        );
    end

    // Opposing steps in the same cycle cancel; held levels are untouched.
    assign bus.freq_up_p = press[FREQ_UP] & ~press[FREQ_DN];
    assign bus.freq_dn_p = press[FREQ_DN] & ~press[FREQ_UP];
    assign bus.seq_up_p  = press[SEQ_UP]  & ~press[SEQ_DN];
    assign bus.seq_dn_p  = press[SEQ_DN]  & ~press[SEQ_UP];
    assign bus.held      = held;

endmodule
